// File: rtl/regfile_pkg.sv
// Shared register-file constants: geometry of the 8-entry file and the fixed
// requester slot assignment on its write port.
package regfile_pkg;

    localparam int RF_AW    = 3;
    localparam int RF_DEPTH = 8;
    localparam int RF_DW    = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;
    localparam int REQ_DBG  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig searching upward from
// ptr and wrapping past NREQ-1 back to index 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   winner,
    output logic [NREQ-1:0] onehot
);

    logic [PW:0] cand;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit holds ptr+k before folding back into 0..NREQ-1,
            // which also covers NREQ values that are not a power of two.
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!valid && elig[cand[PW-1:0]]) begin
                valid  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign onehot[gi] = valid && (winner == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port; one registered
// write per cycle. Define REGFILE_ARB_STATS_EN to add the contention counter.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     gnt,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [7:0]          contention
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] gnt_reg;
    logic            wr_en_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [DW-1:0]   wr_data_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   ptr_next;

    logic [NREQ-1:0] elig;
    logic            pick_valid;
    logic [PW-1:0]   pick_winner;
    logic [NREQ-1:0] pick_onehot;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // The requester granted this cycle sits out the next edge.
    assign elig = req & ~gnt_reg;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    assign ptr_next = (pick_winner == PW'(NREQ - 1)) ? '0 : pick_winner + PW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            ptr_reg     <= '0;
        end else if (pick_valid) begin
            gnt_reg     <= pick_onehot;
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= addr_arr[pick_winner];
            wr_data_reg <= data_arr[pick_winner];
            ptr_reg     <= ptr_next;
        end else begin
            gnt_reg     <= '0;
            wr_en_reg   <= 1'b0;
        end
    end

    assign gnt     = gnt_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

`ifdef REGFILE_ARB_STATS_EN
    logic [7:0] contention_reg;
    logic       contended;

    // Two or more bits set exactly when clearing the lowest set bit leaves some.
    assign contended = |(elig & (elig - NREQ'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            contention_reg <= '0;
        end else if (contended && (contention_reg != 8'hFF)) begin
            contention_reg <= contention_reg + 8'd1;
        end
    end

    assign contention = contention_reg;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized requesters, all compared against a behavioural reference model.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
`ifdef REGFILE_ARB_STATS_EN
    logic [7:0]          contention;
`endif

    regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .contention (contention)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NREQ-1:0] m_gnt;
    logic            m_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    int              m_ptr;
    int              m_cont;
    int              m_writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int w;
        int idx;
        if (!reset) begin
            m_gnt  = '0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_ptr  = 0;
            m_cont = 0;
        end else begin
            elig = req & ~m_gnt;
            if ($countones(elig) >= 2 && m_cont < 255) m_cont++;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && elig[idx]) w = idx;
            end
            if (w >= 0) begin
                m_gnt  = '0;
                m_gnt[w] = 1'b1;
                m_en   = 1'b1;
                m_addr = req_addr[w*AW +: AW];
                m_data = req_data[w*DW +: DW];
                m_ptr  = (w + 1) % NREQ;
                m_writes++;
            end else begin
                m_gnt = '0;
                m_en  = 1'b0;
            end
        end
    endtask

    // One clock: update the model at the edge, compare the DUT just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        $display("cyc t=%0t rst=%b req=%b gnt=%b wr_en=%b addr=%0d data=%h",
                 $time, reset, req, gnt, wr_en, wr_addr, wr_data);
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("wr_en", 32'(wr_en), 32'(m_en));
        check("wr_addr", 32'(wr_addr), 32'(m_addr));
        check("wr_data", 32'(wr_data), 32'(m_data));
`ifdef REGFILE_ARB_STATS_EN
        check("contention", 32'(contention), 32'(m_cont));
`endif
    endtask

    task automatic set_req(input int i, input logic on, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = on;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int writes_before;
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        m_gnt = '0; m_en = 1'b0; m_addr = '0; m_data = '0;
        m_ptr = 0; m_cont = 0; m_writes = 0;

        // Reset held with every requester active, then release.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(16'h0A00 + i));
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        step();
        check("rst_wr_data", 32'(wr_data), 32'h0);
        reset = 1'b1;
        // Immediate re-request by everyone: grants rotate 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            step();
            check("rot_gnt", 32'(gnt), 32'(1 << (n % NREQ)));
            check("rot_data", 32'(wr_data), 32'(16'h0A00 + (n % NREQ)));
        end
        req = '0;
        step();
        check("idle_en", 32'(wr_en), 32'h0);
        check("idle_hold_data", 32'(wr_data), 32'h0A00);

        // Single request from requester 2, then wrap to 3 and 0.
        reset = 1'b0; step(); reset = 1'b1;
        set_req(2, 1'b1, 3'd5, 16'hBEEF);
        step();
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_addr", 32'(wr_addr), 32'd5);
        check("single_data", 32'(wr_data), 32'hBEEF);
        req = 4'b1001;
        step();
        check("wrap_gnt3", 32'(gnt), 32'b1000);
        step();
        check("wrap_gnt0", 32'(gnt), 32'b0001);
        req = '0;
        step();

        // Sole requester 1 held for six cycles: three writes.
        set_req(1, 1'b1, 3'd0, 16'h1111);
        writes_before = m_writes;
        for (int n = 0; n < 6; n++) begin
            step();
            check("sole_gnt", 32'(gnt), (n % 2 == 0) ? 32'b0010 : 32'h0);
        end
        check("sole_writes", 32'(m_writes - writes_before), 32'd3);
        req = '0;
        step();

        // Reset during requester 2's grant cycle cancels it.
        set_req(2, 1'b1, 3'd7, 16'hCAFE);
        step();
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        reset = 1'b0;
        step();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_en", 32'(wr_en), 32'h0);
        reset = 1'b1;
        req = 4'b0110;
        step();
        check("post_rst_gnt", 32'(gnt), 32'b0010);
        step();
        req = '0;
        step();

        // Randomized requesters following the hold-until-granted protocol.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) reset = 1'b0;
            else reset = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !m_gnt[i]) begin
                    // still waiting: hold stable
                end else if ($urandom_range(0, 9) < 6) begin
                    set_req(i, 1'b1, AW'($urandom), DW'($urandom));
                end else begin
                    req[i] = 1'b0;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
